// File: rtl/casefold_pkg.sv
// ---------------------------------------------------------------------------
// casefold_pkg
// Shared definitions for the case-folding front-end and the case-restore
// stage that runs after the decryptor.
//   - state_e      : packer FSM states (FILL, PAD, DONE)
//   - ASCII_*      : letter range boundaries
//   - CASE_OFFSET  : distance between a lowercase letter and its uppercase form
//   - DEFAULT_PAD  : default fill byte for short frames ("X")
//   - is_lower / is_alpha / to_upper : per-byte helpers
// ---------------------------------------------------------------------------
package casefold_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] CASE_OFFSET   = 8'd32;
    localparam logic [7:0] DEFAULT_PAD   = 8'h58;

    // True for 'a'..'z'
    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z);
    endfunction

    // True for 'A'..'Z' or 'a'..'z'
    function automatic logic is_alpha(input logic [7:0] b);
        return is_lower(b) || ((b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z));
    endfunction

    // Folds lowercase letters to uppercase, everything else passes through
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return is_lower(b) ? (b - CASE_OFFSET) : b;
    endfunction

endpackage

// File: rtl/ascii_fold.sv
// ---------------------------------------------------------------------------
// ascii_fold
// Combinational per-byte case fold.
// Ports:
//   byte_i     : input ASCII byte
//   folded_o   : byte with 'a'..'z' mapped to 'A'..'Z'
//   is_lower_o : byte_i was a lowercase letter (i.e. it was folded)
//   is_alpha_o : byte_i was a letter of either case
// ---------------------------------------------------------------------------
module ascii_fold
    import casefold_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] folded_o,
    output logic       is_lower_o,
    output logic       is_alpha_o
);

    assign folded_o   = to_upper(byte_i);
    assign is_lower_o = is_lower(byte_i);
    assign is_alpha_o = is_alpha(byte_i);

endmodule

// File: rtl/casefold_packer.sv
// ---------------------------------------------------------------------------
// casefold_packer
// Accepts plaintext one byte per cycle, folds lowercase to uppercase, and
// packs the folded bytes into MSG_LEN-byte frames together with a case map
// so the downstream case-restore stage can undo the folding. Short messages
// are padded with PAD_CHAR.
//
// Optional feature macro: NONALPHA_ERR_EN
//   defined   -> frame_err flags (sticky per frame) any accepted non-letter
//   undefined -> frame_err is tied to 0
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_data      : plaintext byte
//   in_valid     : in_data valid
//   in_last      : last byte of message (qualified by in_valid)
//   in_ready     : block accepts a byte this cycle
//   frame_data   : packed frame, byte i at [8i+7:8i]
//   case_map     : bit i set when byte i was folded from lowercase
//   frame_len    : number of real (non-pad) bytes
//   frame_err    : frame contained a non-letter byte
//   frame_valid  : frame outputs are valid and stable
//   frame_ready  : consumer takes the frame
// ---------------------------------------------------------------------------
module casefold_packer
    import casefold_pkg::*;
#(
    parameter int         MSG_LEN  = 6,
    parameter logic [7:0] PAD_CHAR = DEFAULT_PAD
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [MSG_LEN*8-1:0]         frame_data,
    output logic [MSG_LEN-1:0]           case_map,
    output logic [$clog2(MSG_LEN+1)-1:0] frame_len,
    output logic                         frame_err,
    output logic                         frame_valid,
    input  logic                         frame_ready
);

    localparam int CNT_W = $clog2(MSG_LEN);
    localparam int LEN_W = $clog2(MSG_LEN+1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MSG_LEN*8-1:0] frameData_q, frameData_d;
    logic [MSG_LEN-1:0]   caseMap_q, caseMap_d;
    logic [LEN_W-1:0]     frameLen_q, frameLen_d;

    logic [7:0] foldByte;
    logic       foldIsLower;
    logic       transfer;

`ifdef NONALPHA_ERR_EN
    logic foldIsAlpha;
    logic frameErr_q, frameErr_d;
`else
    logic unusedIsAlpha;
`endif

    ascii_fold u_fold (
        .byte_i     (in_data),
        .folded_o   (foldByte),
        .is_lower_o (foldIsLower),
`ifdef NONALPHA_ERR_EN
        .is_alpha_o (foldIsAlpha)
`else
        .is_alpha_o (unusedIsAlpha)
`endif
    );

    // in_ready is held low during reset so no byte is taken while the
    // frame is being discarded
    assign in_ready = (state_q == FILL) && !rst;
    assign transfer = in_valid && in_ready;

    // Next-state and datapath update. Bytes are steered into the frame by a
    // compare against cnt_q so every slot is a plain register enable.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frameData_d = frameData_q;
        caseMap_d   = caseMap_q;
        frameLen_d  = frameLen_q;
`ifdef NONALPHA_ERR_EN
        frameErr_d  = frameErr_q;
`endif
        case (state_q)
            FILL: begin
                if (transfer) begin
                    for (int i = 0; i < MSG_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            frameData_d[i*8 +: 8] = foldByte;
                            caseMap_d[i]          = foldIsLower;
                        end
                    end
`ifdef NONALPHA_ERR_EN
                    frameErr_d = frameErr_q || !foldIsAlpha;
`endif
                    if (cnt_q == LAST_IDX) begin
                        // A full frame ignores in_last; no padding needed
                        state_d    = DONE;
                        frameLen_d = LEN_W'(cnt_q) + LEN_W'(1);
                    end else if (in_last) begin
                        state_d    = PAD;
                        frameLen_d = LEN_W'(cnt_q) + LEN_W'(1);
                        cnt_d      = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < MSG_LEN; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        frameData_d[i*8 +: 8] = PAD_CHAR;
                        caseMap_d[i]          = 1'b0;
                    end
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // frame_data is left as-is; refill overwrites every slot
                if (frame_ready) begin
                    state_d   = FILL;
                    cnt_d     = '0;
                    caseMap_d = '0;
`ifdef NONALPHA_ERR_EN
                    frameErr_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // State and frame registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            frameData_q <= '0;
            caseMap_q   <= '0;
            frameLen_q  <= '0;
`ifdef NONALPHA_ERR_EN
            frameErr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frameData_q <= frameData_d;
            caseMap_q   <= caseMap_d;
            frameLen_q  <= frameLen_d;
`ifdef NONALPHA_ERR_EN
            frameErr_q  <= frameErr_d;
`endif
        end
    end

    assign frame_valid = (state_q == DONE);
    assign frame_data  = frameData_q;
    assign case_map    = caseMap_q;
    assign frame_len   = frameLen_q;
`ifdef NONALPHA_ERR_EN
    assign frame_err   = frameErr_q;
`else
    assign frame_err   = 1'b0;
`endif

endmodule
